// File: rtl/vliw_fetch_unit.sv
// VLIW instruction fetch: one 32-bit word per cycle from imem, assembled into
// NSLOT-word bundles, buffered in a 2-entry FIFO behind a valid/ready port.
module vliw_fetch_unit #(
  parameter int NSLOT    = 8,
  parameter int AW       = 16,
  parameter int RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [AW-1:0]       imem_addr,
  input  logic [31:0]         imem_rdata,
  input  logic                redirect_valid,
  input  logic [AW-1:0]       redirect_pc,
  output logic                bundle_valid,
  input  logic                bundle_ready,
  output logic [NSLOT*32-1:0] bundle,
  output logic [AW-1:0]       bundle_pc
);
  localparam int KW = $clog2(NSLOT);
  localparam int BW = NSLOT * 32;
  localparam logic [KW-1:0] K_LAST = KW'(NSLOT - 1);

  typedef enum logic {IDLE, FETCH} state_t;
  state_t state, state_nx;

  logic [AW-1:0]   pc;
  logic [KW-1:0]   k;
  logic [1:0]      count;
  logic            head, tail;
  logic            assembling;
  logic            vld_p1;
  logic [KW-1:0]   k_p1;
  logic [AW-1:0]   asm_pc;
  logic [BW-33:0]  asm_data;
  logic [BW-1:0]   fifo_data [2];
  logic [AW-1:0]   fifo_pc [2];

  logic            push, pop, last_beat, slot_free;
  logic [1:0]      occ;
  logic [BW-1:0]   push_data;

  // rst gates the request so the port reads idle for the whole reset window
  assign imem_req     = (state == FETCH) && !rst;
  assign imem_addr    = imem_req ? pc + AW'(k) : '0;
  assign bundle_valid = (count != 2'd0);
  assign bundle       = bundle_valid ? fifo_data[head] : '0;
  assign bundle_pc    = bundle_valid ? fifo_pc[head] : '0;

  assign pop       = bundle_valid && bundle_ready;
  assign push      = vld_p1 && (k_p1 == K_LAST);
  assign push_data = {asm_data, imem_rdata};
  assign last_beat = imem_req && (k == K_LAST);

  // Occupancy after this cycle's pop, plus the bundle under construction
  assign occ       = count - {1'b0, pop};
  assign slot_free = ({1'b0, occ} + {2'b0, assembling}) < 3'd2;

  always_comb begin
    state_nx = state;
    if (redirect_valid) begin
      state_nx = FETCH;
    end else begin
      case (state)
        IDLE:    if (slot_free) state_nx = FETCH;
        FETCH:   if (last_beat && (occ != 2'd0)) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= AW'(RESET_PC);
      k          <= '0;
      count      <= 2'd0;
      head       <= 1'b0;
      tail       <= 1'b0;
      assembling <= 1'b0;
      vld_p1     <= 1'b0;
    end else begin
      state  <= state_nx;
      // Data for a request issued in a redirect cycle is discarded on arrival
      vld_p1 <= imem_req && !redirect_valid;
      if (redirect_valid) begin
        pc         <= redirect_pc;
        k          <= '0;
        count      <= 2'd0;
        head       <= 1'b0;
        tail       <= 1'b0;
        assembling <= 1'b0;
      end else begin
        if (imem_req) begin
          k <= last_beat ? '0 : k + KW'(1);
          if (last_beat) pc <= pc + AW'(NSLOT);
        end
        if (imem_req && (k == '0)) assembling <= 1'b1;
        else if (push)             assembling <= 1'b0;
        if (push) tail <= ~tail;
        if (pop)  head <= ~head;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  // ---- stage p0 -> p1: request issued, word returns one cycle later ----
  always_ff @(posedge clk) begin
    k_p1 <= k;
    if (imem_req && (k == '0)) asm_pc <= pc;
    if (vld_p1 && (k_p1 != K_LAST))
      asm_data[BW-64-32*int'(k_p1) +: 32] <= imem_rdata;
    if (push) begin
      fifo_data[tail] <= push_data;
      fifo_pc[tail]   <= asm_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !redirect_valid)
      assert (!(push && !pop && count == 2'd2));
  end
endmodule

// File: tb/tb_vliw_fetch_unit.sv
// Self-checking bench for vliw_fetch_unit (NSLOT=8, AW=16, RESET_PC=0).
module tb_vliw_fetch_unit;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         imem_req;
  logic [15:0]  imem_addr;
  logic [31:0]  imem_rdata;
  logic         redirect_valid = 1'b0;
  logic [15:0]  redirect_pc = '0;
  logic         bundle_valid;
  logic         ready = 1'b0;
  logic [255:0] bundle;
  logic [15:0]  bundle_pc;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [65536];

  vliw_fetch_unit #(.NSLOT(8), .AW(16), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .bundle_valid(bundle_valid), .bundle_ready(ready),
    .bundle(bundle), .bundle_pc(bundle_pc)
  );

  always #5 clk = ~clk;

  // Synchronous memory: one-cycle read latency
  always @(posedge clk)
    imem_rdata <= imem_req ? mem[imem_addr] : 32'hDEAD_BEEF;

  typedef struct {
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] bpc;
  } vec_t;
  vec_t vec [27];

  function automatic logic [255:0] model_bundle(input logic [15:0] pc);
    logic [255:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) b[255-32*i -: 32] = mem[16'(pc + 16'(i))];
    return b;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
    #1;
  endtask

  // Leaves the bench at the sample point of cycle 0 (edge 0 still ahead)
  task automatic do_reset();
    rst = 1'b1; ready = 1'b0; redirect_valid = 1'b0;
    next(); next();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_valid(input int c0, input int maxc, output int found);
    int c;
    c = c0;
    while (!bundle_valid && c < c0 + maxc) begin
      next();
      c++;
    end
    found = bundle_valid ? c : -1;
  endtask

  initial begin
    int f;
    int xfers;
    logic [15:0] exp_pc, hold_pc;
    logic [255:0] hold_b;
    logic prev_redir, prev_hold;
    logic [15:0] wrap_addr [8];

    for (int i = 0; i < 65536; i++)
      mem[i] = (i < 16) ? 32'h100 + 32'(i) : ((i % 7 == 0) ? 32'h0 : $urandom);
    for (int c = 0; c < 27; c++)
      vec[c] = '{1'b1, 16'(c), (c >= 9) && ((c - 9) % 8 == 0), 16'(c - 9)};
    wrap_addr = '{16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003};

    // Reset state
    next(); next();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", bundle_valid, 0);
    chk("rst_bundle", bundle, 0);
    chk("rst_bpc", bundle_pc, 0);

    // Startup stream, consumer always ready
    do_reset();
    ready = 1'b1;
    for (int c = 0; c < 27; c++) begin
      chk("t1_req", imem_req, vec[c].req);
      chk("t1_addr", imem_addr, vec[c].addr);
      chk("t1_valid", bundle_valid, vec[c].valid);
      if (vec[c].valid) begin
        chk("t1_bpc", bundle_pc, vec[c].bpc);
        chk("t1_bundle", bundle, model_bundle(vec[c].bpc));
      end
      next();
    end

    // Backpressure: two bundles buffered, fetch stops, resumes after a pop
    do_reset();
    for (int c = 0; c <= 40; c++) begin
      chk("t2_req", imem_req, (c < 16));
      if (c >= 9) chk("t2_valid", bundle_valid, 1);
      next();
    end
    chk("t2_pop0_pc", bundle_pc, 16'h0000);
    chk("t2_pop0_b", bundle, model_bundle(16'h0000));
    ready = 1'b1;
    next();
    chk("t2_resume_req", imem_req, 1);
    chk("t2_resume_addr", imem_addr, 16'd16);
    chk("t2_pop1_pc", bundle_pc, 16'd8);
    chk("t2_pop1_valid", bundle_valid, 1);
    next();
    chk("t2_empty", bundle_valid, 0);
    wait_valid(43, 20, f);
    chk("t2_lat", f, 51);
    chk("t2_pc16", bundle_pc, 16'd16);

    // Redirect mid first bundle
    do_reset();
    ready = 1'b1;
    for (int c = 0; c < 5; c++) next();
    chk("t3_pre_addr", imem_addr, 16'd5);
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    next();
    redirect_valid = 1'b0;
    chk("t3_flush", bundle_valid, 0);
    chk("t3_addr", imem_addr, 16'h0040);
    wait_valid(6, 20, f);
    chk("t3_lat", f, 15);
    chk("t3_bpc", bundle_pc, 16'h0040);
    chk("t3_bundle", bundle, model_bundle(16'h0040));

    // Address wrap across 0xFFFF
    do_reset();
    ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 16'hFFFC;
    next();
    redirect_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk("t4_req", imem_req, 1);
      chk("t4_addr", imem_addr, wrap_addr[c-1]);
      next();
    end
    wait_valid(9, 20, f);
    chk("t4_lat", f, 10);
    chk("t4_bpc", bundle_pc, 16'hFFFC);
    chk("t4_bundle", bundle, model_bundle(16'hFFFC));
    next();
    wait_valid(11, 20, f);
    chk("t4_lat2", f, 18);
    chk("t4_bpc2", bundle_pc, 16'h0004);

    // Redirect coinciding with a handshake while the FIFO is full
    do_reset();
    for (int c = 0; c < 20; c++) next();
    chk("t5_full_valid", bundle_valid, 1);
    chk("t5_full_req", imem_req, 0);
    ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 16'h0080;
    next();
    redirect_valid = 1'b0;
    chk("t5_flush", bundle_valid, 0);
    chk("t5_addr", imem_addr, 16'h0080);
    wait_valid(21, 20, f);
    chk("t5_lat", f, 30);
    chk("t5_bpc", bundle_pc, 16'h0080);
    chk("t5_bundle", bundle, model_bundle(16'h0080));

    // Asynchronous reset mid-bundle
    do_reset();
    for (int c = 0; c < 12; c++) next();
    chk("t6_pre_valid", bundle_valid, 1);
    rst = 1'b1;
    #1;
    chk("t6_req", imem_req, 0);
    chk("t6_addr", imem_addr, 0);
    chk("t6_valid", bundle_valid, 0);
    chk("t6_bundle", bundle, 0);
    chk("t6_bpc", bundle_pc, 0);
    next();
    rst = 1'b0;
    ready = 1'b1;
    #1;
    chk("t6_restart_req", imem_req, 1);
    chk("t6_restart_addr", imem_addr, 0);
    wait_valid(0, 20, f);
    chk("t6_lat", f, 9);
    chk("t6_bpc", bundle_pc, 0);
    chk("t6_bundle", bundle, model_bundle(16'h0000));

    // Random ready/redirect traffic against the bundle-stream model
    do_reset();
    exp_pc = 16'h0000;
    xfers = 0;
    prev_redir = 1'b0; prev_hold = 1'b0;
    hold_pc = '0; hold_b = '0;
    for (int c = 0; c < 3000; c++) begin
      if (prev_redir) chk("rnd_flush", bundle_valid, 0);
      if (prev_hold) begin
        chk("rnd_hold_v", bundle_valid, 1);
        chk("rnd_hold_pc", bundle_pc, hold_pc);
        chk("rnd_hold_b", bundle, hold_b);
      end
      ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc = $urandom_range(0, 1) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom);
      if (bundle_valid && ready && !redirect_valid) begin
        chk("rnd_pc", bundle_pc, exp_pc);
        chk("rnd_bundle", bundle, model_bundle(exp_pc));
        exp_pc = exp_pc + 16'd8;
        xfers++;
      end
      if (redirect_valid) exp_pc = redirect_pc;
      prev_redir = redirect_valid;
      prev_hold  = bundle_valid && !ready && !redirect_valid;
      hold_pc    = bundle_pc;
      hold_b     = bundle;
      next();
    end
    redirect_valid = 1'b0;
    chk("rnd_progress", (xfers > 50), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
